// File: rtl/perceptron_trainer_if.sv
// Execute-side branch stream plus the predictor update port used by the perceptron trainer.
// master = execute/predictor environment, slave = trainer.
interface perceptron_trainer_if #(
  parameter int GHR_SIZE = 12
);
  logic                    execute_valid;
  logic [31:0]             execute_PC4;
  logic [31:0]             execute_target;
  logic                    execute_dir;
  logic                    execute_pred_dir;
  logic [8*GHR_SIZE-1:0]   execute_weights;
  logic [GHR_SIZE-1:0]     execute_ghr;
  logic [7:0]              execute_sum;
  logic                    soin_bpredictor_stall;
  logic                    trainer_full;
  logic                    execute_bpredictor_update;
  logic [31:0]             execute_bpredictor_PC4;
  logic [31:0]             execute_bpredictor_target;
  logic                    execute_bpredictor_dir;
  logic                    execute_bpredictor_miss;
  logic [8*GHR_SIZE-1:0]   execute_bpredictor_data;
  logic [15:0]             trainer_drop_count;

  modport master (
    output execute_valid, execute_PC4, execute_target, execute_dir, execute_pred_dir,
           execute_weights, execute_ghr, execute_sum, soin_bpredictor_stall,
    input  trainer_full, execute_bpredictor_update, execute_bpredictor_PC4,
           execute_bpredictor_target, execute_bpredictor_dir, execute_bpredictor_miss,
           execute_bpredictor_data, trainer_drop_count
  );

  modport slave (
    input  execute_valid, execute_PC4, execute_target, execute_dir, execute_pred_dir,
           execute_weights, execute_ghr, execute_sum, soin_bpredictor_stall,
    output trainer_full, execute_bpredictor_update, execute_bpredictor_PC4,
           execute_bpredictor_target, execute_bpredictor_dir, execute_bpredictor_miss,
           execute_bpredictor_data, trainer_drop_count
  );
endinterface

// File: rtl/perceptron_trainer.sv
// Perceptron predictor trainer: clears the weight tables after reset, then applies the
// saturating perceptron rule to each resolved branch and queues the resulting table writes.
module perceptron_trainer #(
  parameter int GHR_SIZE = 12,
  parameter int ENTRIES  = 64,
  parameter int THETA    = 37,
  parameter int QDEPTH   = 4
) (
  input logic                clk,
  input logic                reset,
  perceptron_trainer_if.slave bus
);
  localparam int DW       = 8 * GHR_SIZE;
  localparam int HOB_BASE = 5 * GHR_SIZE;
  localparam int IDX_W    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int PTR_W    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int OCC_W    = PTR_W + 2;
  localparam int QW       = DW + 66;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);
  localparam logic [8:0]       THETA_9  = 9'(THETA);
  localparam logic [OCC_W-1:0] QDEPTH_O = OCC_W'(QDEPTH);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  function automatic logic [7:0] sat_step(input logic [7:0] w, input logic up);
    logic [7:0] r;
    if (up) r = (w == 8'h7F) ? w : w + 8'd1;
    else    r = (w == 8'h80) ? w : w - 8'd1;
    return r;
  endfunction

  // Weights live split as HOB (3 bits) and LOB (5 bits) fields of the table word.
  function automatic logic [DW-1:0] train_vector(input logic [DW-1:0] base,
                                                 input logic [GHR_SIZE-1:0] ghr,
                                                 input logic dir, input logic en);
    logic [DW-1:0] r;
    logic [7:0]    w;
    r = base;
    for (int i = 0; i < GHR_SIZE; i++) begin
      w = {base[HOB_BASE+3*i +: 3], base[5*i +: 5]};
      w = en ? sat_step(w, dir ~^ ghr[i]) : w;
      r[HOB_BASE+3*i +: 3] = w[7:5];
      r[5*i +: 5]          = w[4:0];
    end
    return r;
  endfunction

  state_t               state_r;
  logic [IDX_W-1:0]     idx_r;
  logic                 s1_valid_r;
  logic [31:0]          s1_pc4_r;
  logic [31:0]          s1_target_r;
  logic                 s1_dir_r;
  logic                 s1_miss_r;
  logic [GHR_SIZE-1:0]  s1_ghr_r;
  logic [7:0]           s1_sum_r;
  logic [DW-1:0]        s1_weights_r;
  logic                 last_valid_r;
  logic [31:0]          last_pc4_r;
  logic [DW-1:0]        last_data_r;
  logic [QW-1:0]        q_mem_r [QDEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [PTR_W:0]       count_r;
  logic [15:0]          drop_count_r;

  logic                 full_s;
  logic                 acc_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 update_s;
  logic                 stall_s;
  logic [OCC_W-1:0]     occ_s;
  logic [DW-1:0]        base_s;
  logic [8:0]           sum_ext_s;
  logic [8:0]           abs_s;
  logic                 do_train_s;
  logic [DW-1:0]        trained_s;
  logic [QW-1:0]        head_s;
  logic [31:0]          out_pc4_s;
  logic [31:0]          out_target_s;
  logic                 out_dir_s;
  logic                 out_miss_s;
  logic [DW-1:0]        out_data_s;

  assign stall_s = bus.soin_bpredictor_stall;
  assign occ_s   = OCC_W'(count_r) + OCC_W'(s1_valid_r);
  assign full_s  = (state_r == ST_INIT) || (occ_s >= QDEPTH_O);
  assign acc_s   = bus.execute_valid && !full_s;
  assign push_s  = s1_valid_r;
  assign pop_s   = (state_r == ST_RUN) && (count_r != '0) && !stall_s;
  assign head_s  = q_mem_r[rd_ptr_r];

  // Training datapath on the S1 snapshot, forwarding the last trained entry for the same PC.
  always_comb begin
    base_s     = (last_valid_r && (last_pc4_r == s1_pc4_r)) ? last_data_r : s1_weights_r;
    sum_ext_s  = {s1_sum_r[7], s1_sum_r};
    abs_s      = s1_sum_r[7] ? (9'd0 - sum_ext_s) : sum_ext_s;
    do_train_s = s1_miss_r || (abs_s <= THETA_9);
    trained_s  = train_vector(base_s, s1_ghr_r, s1_dir_r, do_train_s);
  end

  // Update-port mux: table clear sweep during INIT, queue head during RUN.
  always_comb begin
    update_s     = 1'b0;
    out_pc4_s    = 32'd0;
    out_target_s = 32'd0;
    out_dir_s    = 1'b0;
    out_miss_s   = 1'b0;
    out_data_s   = '0;
    if (state_r == ST_INIT) begin
      update_s  = 1'b1;
      out_pc4_s = 32'({idx_r, 2'b00}) + 32'd4;
    end else begin
      update_s     = (count_r != '0);
      out_pc4_s    = head_s[QW-1 -: 32];
      out_target_s = head_s[QW-33 -: 32];
      out_dir_s    = head_s[DW+1];
      out_miss_s   = head_s[DW];
      out_data_s   = head_s[DW-1:0];
    end
  end

  assign bus.trainer_full              = full_s;
  assign bus.execute_bpredictor_update = update_s;
  assign bus.execute_bpredictor_PC4    = out_pc4_s;
  assign bus.execute_bpredictor_target = out_target_s;
  assign bus.execute_bpredictor_dir    = out_dir_s;
  assign bus.execute_bpredictor_miss   = out_miss_s;
  assign bus.execute_bpredictor_data   = out_data_s;
  assign bus.trainer_drop_count        = drop_count_r;

  // Mode FSM and the table-clear index; the index only moves when the predictor takes the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_INIT;
      idx_r   <= '0;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (!stall_s) begin
            if (idx_r == IDX_LAST) begin
              state_r <= ST_RUN;
              idx_r   <= '0;
            end else begin
              idx_r <= idx_r + 1'b1;
            end
          end
        end
        ST_RUN:  state_r <= ST_RUN;
        default: state_r <= ST_INIT;
      endcase
    end
  end

  // S1 capture of an accepted branch and the saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r   <= 1'b0;
      s1_pc4_r     <= 32'd0;
      s1_target_r  <= 32'd0;
      s1_dir_r     <= 1'b0;
      s1_miss_r    <= 1'b0;
      s1_ghr_r     <= '0;
      s1_sum_r     <= 8'd0;
      s1_weights_r <= '0;
      drop_count_r <= 16'd0;
    end else begin
      s1_valid_r <= acc_s;
      if (acc_s) begin
        s1_pc4_r     <= bus.execute_PC4;
        s1_target_r  <= bus.execute_target;
        s1_dir_r     <= bus.execute_dir;
        s1_miss_r    <= bus.execute_dir ^ bus.execute_pred_dir;
        s1_ghr_r     <= bus.execute_ghr;
        s1_sum_r     <= bus.execute_sum;
        s1_weights_r <= bus.execute_weights;
      end
      if (bus.execute_valid && full_s && (drop_count_r != 16'hFFFF)) begin
        drop_count_r <= drop_count_r + 16'd1;
      end
    end
  end

  // Queue pointers/occupancy and the last-trained-entry forwarding record.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      last_valid_r <= 1'b0;
      last_pc4_r   <= 32'd0;
      last_data_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r     <= wr_ptr_r + 1'b1;
        last_valid_r <= 1'b1;
        last_pc4_r   <= s1_pc4_r;
        last_data_r  <= trained_s;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_mem_r[wr_ptr_r] <= {s1_pc4_r, s1_target_r, s1_dir_r, s1_miss_r, trained_s};
    end
  end
endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed self-checking bench for perceptron_trainer: INIT sweep, training rule,
// saturation, forwarding, backpressure and mid-operation reset.
module tb_perceptron_trainer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  perceptron_trainer_if #(.GHR_SIZE(12)) bus ();

  perceptron_trainer #(.GHR_SIZE(12), .ENTRIES(64), .THETA(37), .QDEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // wv holds 12 signed 8-bit weights, weight i at wv[8i+7:8i]
  function automatic logic [95:0] pack(input logic [95:0] wv);
    logic [95:0] d;
    d = 96'd0;
    for (int i = 0; i < 12; i++) begin
      d[60+3*i +: 3] = wv[8*i+5 +: 3];
      d[5*i +: 5]    = wv[8*i +: 5];
    end
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.execute_valid = 1'b0;
  endtask

  task automatic drive(input logic [31:0] pc4, input logic [31:0] tgt, input logic dir,
                       input logic pred, input logic [95:0] wv, input logic [11:0] ghr,
                       input logic [7:0] sum);
    bus.execute_valid    = 1'b1;
    bus.execute_PC4      = pc4;
    bus.execute_target   = tgt;
    bus.execute_dir      = dir;
    bus.execute_pred_dir = pred;
    bus.execute_weights  = pack(wv);
    bus.execute_ghr      = ghr;
    bus.execute_sum      = sum;
  endtask

  // Leaves the bench in the cycle where the write is at the queue head.
  task automatic send_one(input logic [31:0] pc4, input logic [31:0] tgt, input logic dir,
                          input logic pred, input logic [95:0] wv, input logic [11:0] ghr,
                          input logic [7:0] sum);
    drive(pc4, tgt, dir, pred, wv, ghr, sum);
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.trainer_drop_count !== 16'd0 || bus.trainer_full !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: drop=%0d full=%b, need drop=0 full=1",
               bus.trainer_drop_count, bus.trainer_full);
    end
    for (int i = 0; i < 64; i++) begin
      exp_pc = 32'(i + 1) * 32'd4;
      checks++;
      if (bus.execute_bpredictor_update !== 1'b1 || bus.execute_bpredictor_PC4 !== exp_pc ||
          bus.execute_bpredictor_data !== 96'd0 || bus.trainer_full !== 1'b1 ||
          bus.execute_bpredictor_miss !== 1'b0 || bus.execute_bpredictor_target !== 32'd0) begin
        errors++;
        $display("FAIL init_sweep[%0d]: upd=%b pc4=%h data=%h full=%b, need upd=1 pc4=%h data=0 full=1",
                 i, bus.execute_bpredictor_update, bus.execute_bpredictor_PC4,
                 bus.execute_bpredictor_data, bus.trainer_full, exp_pc);
      end
      tick();
    end
    checks++;
    if (bus.trainer_full !== 1'b0 || bus.execute_bpredictor_update !== 1'b0) begin
      errors++;
      $display("FAIL init_done: full=%b upd=%b, need 0 0", bus.trainer_full,
               bus.execute_bpredictor_update);
    end
  endtask

  task automatic test_init_stall();
    int cyc;
    int exp_idx;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc = 0;
    exp_idx = 0;
    while (bus.trainer_full === 1'b1 && cyc < 200) begin
      bus.soin_bpredictor_stall = (cyc >= 10 && cyc < 13);
      checks++;
      if (bus.execute_bpredictor_PC4 !== 32'(exp_idx * 4 + 4)) begin
        errors++;
        $display("FAIL init_stall_pc[%0d]: pc4=%h need %h", cyc, bus.execute_bpredictor_PC4,
                 32'(exp_idx * 4 + 4));
      end
      if (!bus.soin_bpredictor_stall) exp_idx++;
      tick();
      cyc++;
    end
    bus.soin_bpredictor_stall = 1'b0;
    checks++;
    if (cyc != 67 || exp_idx != 64) begin
      errors++;
      $display("FAIL init_stall_len: cycles=%0d writes=%0d, need 67 and 64", cyc, exp_idx);
    end
  endtask

  task automatic test_mispredict();
    drive(32'h1000, 32'h2000, 1'b1, 1'b0, 96'd0, 12'hFFF, 8'h00);
    tick();
    idle();
    checks++;
    if (bus.execute_bpredictor_update !== 1'b0) begin
      errors++;
      $display("FAIL mispredict_latency: upd=%b one cycle after, need 0",
               bus.execute_bpredictor_update);
    end
    tick();
    checks++;
    if (bus.execute_bpredictor_update !== 1'b1 || bus.execute_bpredictor_PC4 !== 32'h1000 ||
        bus.execute_bpredictor_target !== 32'h2000 || bus.execute_bpredictor_dir !== 1'b1 ||
        bus.execute_bpredictor_miss !== 1'b1 || bus.execute_bpredictor_data !== pack({12{8'h01}})) begin
      errors++;
      $display("FAIL mispredict: upd=%b pc4=%h tgt=%h dir=%b miss=%b data=%h, need 1 1000 2000 1 1 %h",
               bus.execute_bpredictor_update, bus.execute_bpredictor_PC4,
               bus.execute_bpredictor_target, bus.execute_bpredictor_dir,
               bus.execute_bpredictor_miss, bus.execute_bpredictor_data, pack({12{8'h01}}));
    end
    tick();
    checks++;
    if (bus.execute_bpredictor_update !== 1'b0) begin
      errors++;
      $display("FAIL mispredict_drain: upd=%b need 0", bus.execute_bpredictor_update);
    end
  endtask

  task automatic test_confident();
    logic [95:0] w;
    logic [95:0] w2;
    w  = {8'h01, 8'h02, 8'h7F, 8'h80, 8'hFF, 8'h10, 8'hF0, 8'h33, 8'hCC, 8'h05, 8'hFB, 8'h00};
    w2 = {12{8'h10}};
    send_one(32'h1100, 32'h1200, 1'b1, 1'b1, w, 12'h5A3, 8'd50);
    checks++;
    if (bus.execute_bpredictor_data !== pack(w) || bus.execute_bpredictor_miss !== 1'b0 ||
        bus.execute_bpredictor_update !== 1'b1) begin
      errors++;
      $display("FAIL confident_50: data=%h miss=%b, need %h miss=0",
               bus.execute_bpredictor_data, bus.execute_bpredictor_miss, pack(w));
    end
    tick();
    send_one(32'h1104, 32'h1300, 1'b1, 1'b1, w2, 12'hA5C, 8'd37);
    checks++;
    if (bus.execute_bpredictor_data !== pack(96'h110F110F0F110F1111110F0F)) begin
      errors++;
      $display("FAIL theta_37: data=%h need %h", bus.execute_bpredictor_data,
               pack(96'h110F110F0F110F1111110F0F));
    end
    tick();
    send_one(32'h1108, 32'h1400, 1'b0, 1'b0, w2, 12'hFFF, 8'h80);
    checks++;
    if (bus.execute_bpredictor_data !== pack(w2) || bus.execute_bpredictor_dir !== 1'b0) begin
      errors++;
      $display("FAIL sum_m128: data=%h dir=%b, need %h dir=0", bus.execute_bpredictor_data,
               bus.execute_bpredictor_dir, pack(w2));
    end
    tick();
    send_one(32'h110C, 32'h1500, 1'b0, 1'b0, w2, 12'hFFF, 8'hDB);
    checks++;
    if (bus.execute_bpredictor_data !== pack({12{8'h0F}})) begin
      errors++;
      $display("FAIL sum_m37: data=%h need %h", bus.execute_bpredictor_data, pack({12{8'h0F}}));
    end
    tick();
    send_one(32'h1110, 32'h1600, 1'b1, 1'b1, w2, 12'h000, 8'd38);
    checks++;
    if (bus.execute_bpredictor_data !== pack(w2)) begin
      errors++;
      $display("FAIL sum_38: data=%h need %h", bus.execute_bpredictor_data, pack(w2));
    end
    tick();
  endtask

  task automatic test_saturation();
    logic [95:0] exp_w;
    exp_w = {{10{8'hFF}}, 8'h80, 8'h7F};
    send_one(32'h2000, 32'h2100, 1'b1, 1'b0, {80'd0, 8'h80, 8'h7F}, 12'h001, 8'd0);
    checks++;
    if (bus.execute_bpredictor_data !== pack(exp_w) ||
        bus.execute_bpredictor_data[62:60] !== 3'b011 || bus.execute_bpredictor_data[4:0] !== 5'b11111 ||
        bus.execute_bpredictor_data[65:63] !== 3'b100 || bus.execute_bpredictor_data[9:5] !== 5'b00000) begin
      errors++;
      $display("FAIL saturation: data=%h need %h", bus.execute_bpredictor_data, pack(exp_w));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(32'h3000, 32'h3100, 1'b1, 1'b0, 96'd0, 12'hFFF, 8'd0);
    tick();
    drive(32'h3000, 32'h3100, 1'b1, 1'b0, 96'd0, 12'hFFF, 8'd0);
    tick();
    idle();
    checks++;
    if (bus.execute_bpredictor_update !== 1'b1 || bus.execute_bpredictor_data !== pack({12{8'h01}})) begin
      errors++;
      $display("FAIL fwd_first: upd=%b data=%h need 1 %h", bus.execute_bpredictor_update,
               bus.execute_bpredictor_data, pack({12{8'h01}}));
    end
    tick();
    checks++;
    if (bus.execute_bpredictor_update !== 1'b1 || bus.execute_bpredictor_PC4 !== 32'h3000 ||
        bus.execute_bpredictor_data !== pack({12{8'h02}})) begin
      errors++;
      $display("FAIL fwd_second: upd=%b pc4=%h data=%h need 1 3000 %h", bus.execute_bpredictor_update,
               bus.execute_bpredictor_PC4, bus.execute_bpredictor_data, pack({12{8'h02}}));
    end
    tick();
    checks++;
    if (bus.execute_bpredictor_update !== 1'b0) begin
      errors++;
      $display("FAIL fwd_drain: upd=%b need 0", bus.execute_bpredictor_update);
    end
    send_one(32'h3000, 32'h3100, 1'b1, 1'b0, 96'd0, 12'hFFF, 8'd0);
    checks++;
    if (bus.execute_bpredictor_data !== pack({12{8'h03}})) begin
      errors++;
      $display("FAIL fwd_later: data=%h need %h", bus.execute_bpredictor_data, pack({12{8'h03}}));
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] pc;
    bus.soin_bpredictor_stall = 1'b1;
    for (int k = 0; k < 6; k++) begin
      pc = 32'h4000 + 32'(16 * k);
      drive(pc, 32'h5000, 1'b1, 1'b0, 96'd0, 12'hFFF, 8'd0);
      checks++;
      if (bus.trainer_full !== (k >= 4)) begin
        errors++;
        $display("FAIL bp_full[%0d]: full=%b need %b", k, bus.trainer_full, (k >= 4));
      end
      tick();
    end
    idle();
    tick();
    tick();
    checks++;
    if (bus.trainer_full !== 1'b1 || bus.execute_bpredictor_update !== 1'b1 ||
        bus.execute_bpredictor_PC4 !== 32'h4000 || bus.trainer_drop_count !== 16'd2) begin
      errors++;
      $display("FAIL bp_hold: full=%b upd=%b pc4=%h drop=%0d, need 1 1 4000 2", bus.trainer_full,
               bus.execute_bpredictor_update, bus.execute_bpredictor_PC4, bus.trainer_drop_count);
    end
    bus.soin_bpredictor_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pc = 32'h4000 + 32'(16 * k);
      checks++;
      if (bus.execute_bpredictor_update !== 1'b1 || bus.execute_bpredictor_PC4 !== pc ||
          bus.execute_bpredictor_data !== pack({12{8'h01}}) || bus.trainer_full !== (k == 0)) begin
        errors++;
        $display("FAIL bp_drain[%0d]: upd=%b pc4=%h full=%b data=%h, need 1 %h %b %h", k,
                 bus.execute_bpredictor_update, bus.execute_bpredictor_PC4, bus.trainer_full,
                 bus.execute_bpredictor_data, pc, (k == 0), pack({12{8'h01}}));
      end
      tick();
    end
    checks++;
    if (bus.execute_bpredictor_update !== 1'b0 || bus.trainer_full !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: upd=%b full=%b need 0 0", bus.execute_bpredictor_update,
               bus.trainer_full);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bus.soin_bpredictor_stall = 1'b1;
    drive(32'h6000, 32'h6100, 1'b1, 1'b0, 96'd0, 12'hFFF, 8'd0);
    tick();
    idle();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.soin_bpredictor_stall = 1'b0;
    checks++;
    if (bus.execute_bpredictor_update !== 1'b1 || bus.execute_bpredictor_PC4 !== 32'd4 ||
        bus.execute_bpredictor_data !== 96'd0 || bus.trainer_full !== 1'b1 ||
        bus.trainer_drop_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: upd=%b pc4=%h full=%b drop=%0d, need 1 4 1 0",
               bus.execute_bpredictor_update, bus.execute_bpredictor_PC4, bus.trainer_full,
               bus.trainer_drop_count);
    end
    cyc = 0;
    while (bus.trainer_full === 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc != 64) begin
      errors++;
      $display("FAIL reset_mid_sweep: cycles=%0d need 64", cyc);
    end
    send_one(32'h3000, 32'h3100, 1'b1, 1'b0, 96'd0, 12'hFFF, 8'd0);
    checks++;
    if (bus.execute_bpredictor_data !== pack({12{8'h01}})) begin
      errors++;
      $display("FAIL reset_clears_last: data=%h need %h", bus.execute_bpredictor_data,
               pack({12{8'h01}}));
    end
    tick();
  endtask

  initial begin
    bus.execute_valid         = 1'b0;
    bus.execute_PC4           = 32'd0;
    bus.execute_target        = 32'd0;
    bus.execute_dir           = 1'b0;
    bus.execute_pred_dir      = 1'b0;
    bus.execute_weights       = 96'd0;
    bus.execute_ghr           = 12'd0;
    bus.execute_sum           = 8'd0;
    bus.soin_bpredictor_stall = 1'b0;
    test_reset();
    test_init_stall();
    test_mispredict();
    test_confident();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
